// File: rtl/if_fetch_stage_pkg.sv
// Shared pipeline definitions: front-end widths, reset PC, fetch FSM states
// and the NOP word that IF/ID uses to fill a bubble.
package if_fetch_stage_pkg;

   localparam int          PIPE_XLEN     = 32;
   localparam logic [31:0] PIPE_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] PIPE_NOP      = 32'h0000_0013;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      WAIT    = 2'd1,
      DISCARD = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_perf_counters.sv
// Pair of free-running, wrapping event counters with individual enables.
// Generic so the same block can count I-cache or D-cache events.
module fetch_perf_counters #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc0,
   input  logic             inc1,
   output logic [CNT_W-1:0] count0,
   output logic [CNT_W-1:0] count1
);

   logic [1:0]       inc;
   logic [CNT_W-1:0] count_reg [2];

   assign inc = {inc1, inc0};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_cnt
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               count_reg[gi] <= '0;
            end else if (inc[gi]) begin
               count_reg[gi] <= count_reg[gi] + CNT_W'(1);
            end
         end
      end
   endgenerate

   assign count0 = count_reg[0];
   assign count1 = count_reg[1];

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the I-cache request, handles
// EX redirects, hazard stalls and squashing of fetches made stale by a redirect.
module if_fetch_stage
   import if_fetch_stage_pkg::*;
#(
   parameter int              XLEN     = PIPE_XLEN,
   parameter logic [XLEN-1:0] RESET_PC = PIPE_RESET_PC,
   parameter int              CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             redirect,
   input  logic [XLEN-1:0]  redirect_target,
   output logic             imem_req,
   output logic [XLEN-1:0]  imem_addr,
   input  logic [XLEN-1:0]  imem_rdata,
   input  logic             imem_ready,
   output logic [XLEN-1:0]  pc,
   output logic [XLEN-1:0]  pcAdd4,
   output logic [XLEN-1:0]  inst,
   output logic             if_valid,
   output logic             fetch_stall,
   output logic             misalign_err,
   output logic [CNT_W-1:0] fetch_count,
   output logic [CNT_W-1:0] miss_cycles
);

   fetch_state_t    state;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] req_addr_q;
   logic [XLEN-1:0] cur_addr;
   logic [XLEN-1:0] aligned_target;
   logic            in_discard;
   logic            misalign_q;
   logic            fetch_en;

   // While a request is outstanding the cache sees the latched address, so
   // pc_q is free to hold a redirect target in DISCARD.
   assign cur_addr       = (state == FETCH) ? pc_q : req_addr_q;
   assign aligned_target = {redirect_target[XLEN-1:2], 2'b00};
   assign in_discard     = (state == DISCARD);

   assign imem_req     = ~reset;
   assign imem_addr    = cur_addr;
   assign pc           = cur_addr;
   assign pcAdd4       = cur_addr + XLEN'(4);
   assign if_valid     = ~reset & imem_ready & ~in_discard;
   assign fetch_stall  = ~reset & (~imem_ready | in_discard);
   assign inst         = if_valid ? imem_rdata : '0;
   assign misalign_err = misalign_q;
   assign fetch_en     = if_valid & ~stall & ~redirect;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= FETCH;
         pc_q       <= RESET_PC;
         req_addr_q <= '0;
         misalign_q <= 1'b0;
      end else if (redirect) begin
         pc_q <= aligned_target;
         if (redirect_target[1:0] != 2'b00) begin
            misalign_q <= 1'b1;
         end
         if (!imem_ready) begin
            state <= DISCARD;
            if (state == FETCH) begin
               req_addr_q <= pc_q;
            end
         end else begin
            state <= FETCH;
         end
      end else if (stall) begin
         // In DISCARD pc_q already holds the redirect target; keep it.
         if (!in_discard) begin
            pc_q <= cur_addr;
         end
         if (!imem_ready) begin
            if (state == FETCH) begin
               state      <= WAIT;
               req_addr_q <= pc_q;
            end
         end else begin
            state <= FETCH;
         end
      end else if (imem_ready) begin
         if (!in_discard) begin
            pc_q <= cur_addr + XLEN'(4);
         end
         state <= FETCH;
      end else if (state == FETCH) begin
         state      <= WAIT;
         req_addr_q <= pc_q;
      end
   end

   fetch_perf_counters #(
      .CNT_W (CNT_W)
   ) u_perf (
      .clk    (clk),
      .reset  (reset),
      .inc0   (fetch_en),
      .inc1   (fetch_stall),
      .count0 (fetch_count),
      .count1 (miss_cycles)
   );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: expected presentations are queued by the
// stimulus and popped by a negedge monitor whenever if_valid is seen.
module tb_if_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic [31:0] pc;
   logic [31:0] pcAdd4;
   logic [31:0] inst;
   logic        if_valid;
   logic        fetch_stall;
   logic        misalign_err;
   logic [31:0] fetch_count;
   logic [31:0] miss_cycles;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   // Memory model: instruction word is the address with the top two bits set.
   assign imem_rdata = imem_addr | 32'hC000_0000;

   if_fetch_stage #(
      .XLEN     (32),
      .RESET_PC (32'h0000_0000),
      .CNT_W    (32)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .stall           (stall),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_rdata      (imem_rdata),
      .imem_ready      (imem_ready),
      .pc              (pc),
      .pcAdd4          (pcAdd4),
      .inst            (inst),
      .if_valid        (if_valid),
      .fetch_stall     (fetch_stall),
      .misalign_err    (misalign_err),
      .fetch_count     (fetch_count),
      .miss_cycles     (miss_cycles)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
      end else begin
         $display("ok   %s = %h t=%0t", name, act, $time);
      end
   endtask

   task automatic push(input logic [31:0] p, input logic [31:0] i);
      exp_t e;
      e.pc   = p;
      e.inst = i;
      sb.push_back(e);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (if_valid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid actual pc=%h required no valid t=%0t", pc, $time);
         end else begin
            e = sb.pop_front();
            chk("mon_pc", pc, e.pc);
            chk("mon_inst", inst, e.inst);
            chk("mon_pcadd4", pcAdd4, e.pc + 32'd4);
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; stall = 1'b0; redirect = 1'b0;
      redirect_target = 32'h0; imem_ready = 1'b1;
      #2;
      chk("rst_req",    {31'd0, imem_req},    32'd0);
      chk("rst_valid",  {31'd0, if_valid},    32'd0);
      chk("rst_fstall", {31'd0, fetch_stall}, 32'd0);
      chk("rst_inst",   inst,                 32'd0);
      chk("rst_pc",     pc,                   32'h0);
      chk("rst_fcount", fetch_count,          32'd0);

      // Straight-line hits from RESET_PC
      cyc();
      reset = 1'b0;
      push(32'h0, 32'hC000_0000); push(32'h4, 32'hC000_0004);
      push(32'h8, 32'hC000_0008); push(32'hC, 32'hC000_000C);
      repeat (4) cyc();
      chk("hits_fcount", fetch_count, 32'd4);
      chk("hits_addr",   imem_addr,   32'h10);

      // Three-cycle miss at 0x10
      imem_ready = 1'b0;
      #1;
      chk("miss_addr0",   imem_addr,              32'h10);
      chk("miss_fstall0", {31'd0, fetch_stall},   32'd1);
      cyc();
      chk("miss_addr1",   imem_addr,              32'h10);
      chk("miss_fstall1", {31'd0, fetch_stall},   32'd1);
      cyc();
      chk("miss_addr2",   imem_addr,              32'h10);
      cyc();
      imem_ready = 1'b1;
      push(32'h10, 32'hC000_0010);
      cyc();
      chk("miss_cycles3", miss_cycles, 32'd3);
      chk("miss_next",    imem_addr,   32'h14);
      chk("miss_fcount",  fetch_count, 32'd5);

      // Redirect to 0x100 while 0x20 is missing
      push(32'h14, 32'hC000_0014); push(32'h18, 32'hC000_0018);
      push(32'h1C, 32'hC000_001C);
      repeat (3) cyc();
      imem_ready = 1'b0;
      cyc();
      redirect = 1'b1; redirect_target = 32'h100;
      cyc();
      redirect = 1'b0;
      #1;
      chk("disc_addr",  imem_addr,          32'h20);
      chk("disc_valid", {31'd0, if_valid},  32'd0);
      cyc();
      imem_ready = 1'b1;
      #1;
      chk("disc_rdy_valid", {31'd0, if_valid}, 32'd0);
      chk("disc_rdy_addr",  imem_addr,         32'h20);
      chk("disc_rdy_inst",  inst,              32'd0);
      push(32'h100, 32'hC000_0100);
      cyc();
      chk("redir_addr", imem_addr, 32'h100);
      cyc();
      chk("redir_miss",   miss_cycles, 32'd7);
      chk("redir_fcount", fetch_count, 32'd9);

      // Redirect back to 0x8 on a hit, then hold with stall for two cycles
      push(32'h104, 32'hC000_0104);
      redirect = 1'b1; redirect_target = 32'h8;
      cyc();
      redirect = 1'b0; stall = 1'b1;
      push(32'h8, 32'hC000_0008);
      #1;
      chk("stall_addr0", imem_addr, 32'h8);
      cyc();
      push(32'h8, 32'hC000_0008);
      chk("stall_addr1",   imem_addr,   32'h8);
      chk("stall_fcount",  fetch_count, 32'd9);
      cyc();
      stall = 1'b0;
      push(32'h8, 32'hC000_0008);
      cyc();
      push(32'hC, 32'hC000_000C);
      chk("resume_addr", imem_addr, 32'hC);
      cyc();
      chk("resume_fcount", fetch_count, 32'd11);

      // Redirect and stall together: redirect wins
      push(32'h10, 32'hC000_0010);
      redirect = 1'b1; stall = 1'b1; redirect_target = 32'h40;
      cyc();
      chk("rs_addr", imem_addr, 32'h40);
      // Misaligned target 0x42 is forced to 0x40 and flagged
      stall = 1'b0; redirect_target = 32'h42;
      push(32'h40, 32'hC000_0040);
      cyc();
      redirect = 1'b0;
      #1;
      chk("mis_addr", imem_addr,             32'h40);
      chk("mis_flag", {31'd0, misalign_err}, 32'd1);
      push(32'h40, 32'hC000_0040);
      cyc();
      imem_ready = 1'b0;
      chk("mis_sticky", {31'd0, misalign_err}, 32'd1);
      chk("mis_next",   imem_addr,             32'h44);
      chk("mis_fcount", fetch_count,           32'd12);

      // Asynchronous reset while waiting on 0x44
      cyc();
      chk("wait_addr", imem_addr, 32'h44);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_pc",       pc,                    32'h0);
      chk("arst_req",      {31'd0, imem_req},     32'd0);
      chk("arst_fstall",   {31'd0, fetch_stall},  32'd0);
      chk("arst_misalign", {31'd0, misalign_err}, 32'd0);
      chk("arst_fcount",   fetch_count,           32'd0);
      chk("arst_miss",     miss_cycles,           32'd0);

      // PC+4 wrap at the top of the address space
      cyc();
      reset = 1'b0; imem_ready = 1'b1;
      redirect = 1'b1; redirect_target = 32'hFFFF_FFFC;
      push(32'h0, 32'hC000_0000);
      cyc();
      redirect = 1'b0;
      push(32'hFFFF_FFFC, 32'hFFFF_FFFC);
      #1;
      chk("wrap_addr",   imem_addr, 32'hFFFF_FFFC);
      chk("wrap_pcadd4", pcAdd4,    32'h0);
      cyc();
      chk("wrap_next", imem_addr, 32'h0);
      push(32'h0, 32'hC000_0000);
      cyc();
      chk("wrap_fcount", fetch_count, 32'd2);
      chk("sb_drained",  sb.size(),   32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
